// File: rtl/rah_tx_arbiter.sv
// RAH TX-queue write-port arbiter: one-entry buffer per responder, round-robin issue with
// multi-word lock, throttled by q_full. Optional counters under macro RAH_ARB_STATS_EN.
module rah_tx_arbiter #(
  parameter int RAH_PACKET_WIDTH = 48,
  parameter int NUM_SRC          = 4,
  parameter int SRC_IDX_W        = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SRC-1:0]                  src_w_en,
  input  logic [NUM_SRC-1:0]                  src_lock,
  input  logic [NUM_SRC*RAH_PACKET_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]                  src_busy,
  input  logic                                q_full,
  output logic                                w_en,
  output logic [RAH_PACKET_WIDTH-1:0]         out_data,
  output logic [SRC_IDX_W-1:0]                grant_idx,
  output logic [NUM_SRC-1:0]                  overflow
`ifdef RAH_ARB_STATS_EN
  ,
  output logic [NUM_SRC*16-1:0]               stat_grants,
  output logic [15:0]                         stat_stall
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t                      r_state, w_state_nxt;
  logic [SRC_IDX_W-1:0]        r_rr, w_rr_nxt, r_lock_src, w_lock_src_nxt, w_sel;
  logic [NUM_SRC-1:0]          r_pend, r_lockbit, r_ovf, w_issue_vec;
  logic [RAH_PACKET_WIDTH-1:0] r_buf [NUM_SRC];
  logic [RAH_PACKET_WIDTH-1:0] w_sel_data;
  logic                        w_sel_lock, w_valid, w_issue;
  int                          w_best, w_d;

  assign src_busy = r_pend;
  assign overflow = r_ovf;

  // Source selection: locked source only, else nearest pending source after r_rr
  always_comb begin
    w_sel   = '0;
    w_valid = 1'b0;
    w_best  = NUM_SRC;
    w_d     = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      w_d = (j + NUM_SRC + NUM_SRC - int'(r_rr) - 32'sd1) % NUM_SRC;
      if (r_state == S_LOCKED) begin
        if (SRC_IDX_W'(j) == r_lock_src) begin
          w_sel   = r_lock_src;
          w_valid = r_pend[j];
        end else begin
          w_valid = w_valid;
        end
      end else if (r_pend[j] && (w_d < w_best)) begin
        w_best  = w_d;
        w_sel   = SRC_IDX_W'(j);
        w_valid = 1'b1;
      end else begin
        w_best  = w_best;
      end
    end
  end

  // Issue decision and selected-buffer mux
  always_comb begin
    w_issue    = w_valid & ~q_full;
    w_sel_data = '0;
    w_sel_lock = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      w_issue_vec[j] = w_issue && (w_sel == SRC_IDX_W'(j));
      w_sel_data     = (w_sel == SRC_IDX_W'(j)) ? r_buf[j] : w_sel_data;
      w_sel_lock     = (w_sel == SRC_IDX_W'(j)) ? r_lockbit[j] : w_sel_lock;
    end
  end

  // FSM next state: a locked word holds the grant and the pointer; an unlocked word releases
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_nxt       = r_rr;
    w_lock_src_nxt = r_lock_src;
    if (w_issue) begin
      if (w_sel_lock) begin
        w_state_nxt    = S_LOCKED;
        w_lock_src_nxt = w_sel;
      end else begin
        w_state_nxt    = S_IDLE;
        w_rr_nxt       = w_sel;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, holding buffers and registered TX-queue write side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr       <= '0;
      r_lock_src <= '0;
      r_pend     <= '0;
      r_lockbit  <= '0;
      r_ovf      <= '0;
      w_en       <= 1'b0;
      out_data   <= '0;
      grant_idx  <= '0;
      for (int j = 0; j < NUM_SRC; j++) r_buf[j] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr       <= w_rr_nxt;
      r_lock_src <= w_lock_src_nxt;
      w_en       <= w_issue;
      if (w_issue) begin
        out_data  <= w_sel_data;
        grant_idx <= w_sel;
      end
      // A buffer emptied by this edge's issue can take a new word on the same edge
      for (int j = 0; j < NUM_SRC; j++) begin
        if (src_w_en[j] && (!r_pend[j] || w_issue_vec[j])) begin
          r_buf[j]     <= src_data[j*RAH_PACKET_WIDTH +: RAH_PACKET_WIDTH];
          r_lockbit[j] <= src_lock[j];
          r_pend[j]    <= 1'b1;
        end else if (src_w_en[j]) begin
          r_ovf[j]     <= 1'b1;
        end else if (w_issue_vec[j]) begin
          r_pend[j]    <= 1'b0;
        end
      end
    end
  end

`ifdef RAH_ARB_STATS_EN
  logic [15:0] r_stat_grants [NUM_SRC];
  logic [15:0] r_stat_stall;

  // Saturating per-source grant counters and stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_stall <= 16'h0000;
      for (int j = 0; j < NUM_SRC; j++) r_stat_grants[j] <= 16'h0000;
    end else begin
      if ((|r_pend) && q_full && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'h0001;
      end
      for (int j = 0; j < NUM_SRC; j++) begin
        if (w_issue_vec[j] && (r_stat_grants[j] != 16'hFFFF)) begin
          r_stat_grants[j] <= r_stat_grants[j] + 16'h0001;
        end
      end
    end
  end

  assign stat_stall = r_stat_stall;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = r_stat_grants[g];
  end
`endif

endmodule

// File: tb/tb_rah_tx_arbiter.sv
// Directed self-checking bench for rah_tx_arbiter (default build, 4 sources, 48-bit words).
module tb_rah_tx_arbiter;
  localparam int W = 48;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   src_w_en;
  logic [N-1:0]   src_lock;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_busy;
  logic           q_full;
  logic           w_en;
  logic [W-1:0]   out_data;
  logic [2:0]     grant_idx;
  logic [N-1:0]   overflow;

  int n_checks = 0;
  int n_pass   = 0;

  rah_tx_arbiter #(.RAH_PACKET_WIDTH(W), .NUM_SRC(N), .SRC_IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .src_w_en(src_w_en), .src_lock(src_lock),
    .src_data(src_data), .src_busy(src_busy), .q_full(q_full), .w_en(w_en),
    .out_data(out_data), .grant_idx(grant_idx), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0; src_w_en = '0; src_lock = '0; src_data = '0; q_full = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if ({w_en, src_busy, overflow, grant_idx} !== 12'h000) $display("FAIL reset_ctl: got %0h expected 0", {w_en, src_busy, overflow, grant_idx}); else n_pass++;
    n_checks++; if (out_data !== 48'h0) $display("FAIL reset_data: got %0h expected 0", out_data); else n_pass++;
  endtask

  task automatic test_single();
    apply_reset();
    src_w_en = 4'b0001; src_data[0 +: W] = 48'h00_0000_0001_02;
    @(negedge clk);
    src_w_en = 4'b0000;
    n_checks++; if (w_en !== 1'b0) $display("FAIL single_early_wen: got %0b expected 0", w_en); else n_pass++;
    n_checks++; if (src_busy !== 4'b0001) $display("FAIL single_busy: got %0b expected 0001", src_busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (w_en !== 1'b1) $display("FAIL single_wen: got %0b expected 1", w_en); else n_pass++;
    n_checks++; if (out_data !== 48'h00_0000_0001_02) $display("FAIL single_data: got %0h expected 000000000102", out_data); else n_pass++;
    n_checks++; if (grant_idx !== 3'd0) $display("FAIL single_grant: got %0d expected 0", grant_idx); else n_pass++;
    n_checks++; if (src_busy !== 4'b0000) $display("FAIL single_busy_clr: got %0b expected 0000", src_busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (w_en !== 1'b0) $display("FAIL single_wen_off: got %0b expected 0", w_en); else n_pass++;
  endtask

  task automatic test_round_robin();
    int exp_ord [4] = '{1, 2, 3, 0};
    logic [W-1:0] exp_d;
    apply_reset();
    src_w_en = 4'b1111;
    for (int i = 0; i < N; i++) src_data[i*W +: W] = 48'hA0 + 48'(i);
    @(negedge clk);
    src_w_en = 4'b0000;
    n_checks++; if (src_busy !== 4'b1111) $display("FAIL rr_busy: got %0b expected 1111", src_busy); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_d = 48'hA0 + 48'(exp_ord[k]);
      n_checks++; if (w_en !== 1'b1 || grant_idx !== 3'(exp_ord[k]) || out_data !== exp_d)
        $display("FAIL rr_issue%0d: got wen=%0b grant=%0d data=%0h expected wen=1 grant=%0d data=%0h", k, w_en, grant_idx, out_data, exp_ord[k], exp_d);
      else n_pass++;
    end
    n_checks++; if (overflow !== 4'b0000) $display("FAIL rr_ovf: got %0b expected 0000", overflow); else n_pass++;
  endtask

  task automatic test_q_full();
    apply_reset();
    q_full = 1'b1;
    src_w_en = 4'b0110; src_data[1*W +: W] = 48'hC1; src_data[2*W +: W] = 48'hC2;
    @(negedge clk);
    src_w_en = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (w_en !== 1'b0 || src_busy !== 4'b0110) $display("FAIL qfull_hold%0d: got wen=%0b busy=%0b expected wen=0 busy=0110", k, w_en, src_busy); else n_pass++;
    end
    q_full = 1'b0;
    @(negedge clk);
    n_checks++; if (w_en !== 1'b1 || grant_idx !== 3'd1 || out_data !== 48'hC1) $display("FAIL qfull_first: got wen=%0b grant=%0d data=%0h expected 1/1/c1", w_en, grant_idx, out_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (w_en !== 1'b1 || grant_idx !== 3'd2 || out_data !== 48'hC2) $display("FAIL qfull_second: got wen=%0b grant=%0d data=%0h expected 1/2/c2", w_en, grant_idx, out_data); else n_pass++;
  endtask

  task automatic test_lock();
    apply_reset();
    src_w_en = 4'b0010; src_data[1*W +: W] = 48'hD0;
    @(negedge clk);
    src_w_en = 4'b0000;
    @(negedge clk);
    n_checks++; if (grant_idx !== 3'd1 || w_en !== 1'b1) $display("FAIL lock_pre: got grant=%0d wen=%0b expected 1/1", grant_idx, w_en); else n_pass++;
    // rr now 1: source 2 is searched first
    q_full = 1'b1;
    src_w_en = 4'b0110; src_lock = 4'b0100;
    src_data[1*W +: W] = 48'hE1; src_data[2*W +: W] = 48'h2A;
    @(negedge clk);
    q_full = 1'b0;
    src_w_en = 4'b0100; src_lock = 4'b0100; src_data[2*W +: W] = 48'h2B;
    @(negedge clk);
    n_checks++; if (w_en !== 1'b1 || grant_idx !== 3'd2 || out_data !== 48'h2A) $display("FAIL lock_2a: got wen=%0b grant=%0d data=%0h expected 1/2/2a", w_en, grant_idx, out_data); else n_pass++;
    src_lock = 4'b0000; src_data[2*W +: W] = 48'h2C;
    @(negedge clk);
    src_w_en = 4'b0000;
    n_checks++; if (w_en !== 1'b1 || grant_idx !== 3'd2 || out_data !== 48'h2B) $display("FAIL lock_2b: got wen=%0b grant=%0d data=%0h expected 1/2/2b", w_en, grant_idx, out_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (w_en !== 1'b1 || grant_idx !== 3'd2 || out_data !== 48'h2C) $display("FAIL lock_2c: got wen=%0b grant=%0d data=%0h expected 1/2/2c", w_en, grant_idx, out_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (w_en !== 1'b1 || grant_idx !== 3'd1 || out_data !== 48'hE1) $display("FAIL lock_src1: got wen=%0b grant=%0d data=%0h expected 1/1/e1", w_en, grant_idx, out_data); else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    q_full = 1'b1;
    src_w_en = 4'b1000; src_data[3*W +: W] = 48'hF1;
    @(negedge clk);
    src_data[3*W +: W] = 48'hF2;
    @(negedge clk);
    src_w_en = 4'b0000;
    n_checks++; if (overflow !== 4'b1000 || src_busy !== 4'b1000) $display("FAIL ovf_set: got ovf=%0b busy=%0b expected 1000/1000", overflow, src_busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (overflow !== 4'b1000 || w_en !== 1'b0) $display("FAIL ovf_sticky: got ovf=%0b wen=%0b expected 1000/0", overflow, w_en); else n_pass++;
    q_full = 1'b0;
    @(negedge clk);
    n_checks++; if (w_en !== 1'b1 || grant_idx !== 3'd3 || out_data !== 48'hF1) $display("FAIL ovf_kept: got wen=%0b grant=%0d data=%0h expected 1/3/f1", w_en, grant_idx, out_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (w_en !== 1'b0 || out_data !== 48'hF1) $display("FAIL ovf_dropped: got wen=%0b data=%0h expected 0/f1", w_en, out_data); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (overflow !== 4'b0000) $display("FAIL ovf_reset: got %0b expected 0000", overflow); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      src_w_en = 4'b0001; src_data[0 +: W] = 48'h100 + 48'(k);
      @(negedge clk);
      if (k == 0) begin
        n_checks++; if (w_en !== 1'b0) $display("FAIL b2b_first: got wen=%0b expected 0", w_en); else n_pass++;
      end else begin
        n_checks++; if (w_en !== 1'b1 || out_data !== 48'h100 + 48'(k - 1)) $display("FAIL b2b_word%0d: got wen=%0b data=%0h expected 1/%0h", k - 1, w_en, out_data, 48'h100 + 48'(k - 1)); else n_pass++;
      end
    end
    src_w_en = 4'b0000;
    @(negedge clk);
    n_checks++; if (w_en !== 1'b1 || out_data !== 48'h105) $display("FAIL b2b_last: got wen=%0b data=%0h expected 1/105", w_en, out_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (w_en !== 1'b0 || overflow !== 4'b0000) $display("FAIL b2b_end: got wen=%0b ovf=%0b expected 0/0000", w_en, overflow); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_q_full();
    test_lock();
    test_overflow();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
